mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/arb_timer.sv | 30 +++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types and default widths.
// Imported by the interface, the timer and the arbiter top.
package mem_arb_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_WAIT_LIMIT   = 15;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch/data requester ports plus the shared memory port.
// slave = arbiter view, master = requesters and memory.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;

  logic              err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata, mem_ack,
    output if_done, if_rdata,
    output d_done, d_rdata, err,
    output mem_req, mem_we,
    output mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata, mem_ack,
    input  if_done, if_rdata,
    input  d_done, d_rdata, err,
    input  mem_req, mem_we,
    input  mem_addr, mem_wdata
  );

endinterface

// File: rtl/arb_timer.sv
// Wait-state counter for one memory access.
// expired fires in the LIMIT-th enabled cycle.
module arb_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;

  assign expired = en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store.
// Data-over-fetch priority with starvation limit and timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int WAIT_LIMIT   = DEF_WAIT_LIMIT,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_t state_q;
  state_t state_d;
  owner_t owner_q;

  logic [SW-1:0]     starve_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_done_q;
  logic              d_done_q;
  logic              err_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic              starve_full;
  logic              fetch_wins;
  logic              data_wins;
  logic              grant_if;
  logic              grant_d;
  logic              in_access;
  logic              expired;
  logic              complete;
  logic [DATA_W-1:0] rd;

  assign starve_full = (starve_q == STARVE_MAX);
  assign fetch_wins  = bus.if_req && (!bus.d_req || starve_full);
  assign data_wins   = bus.d_req && !fetch_wins;
  assign in_access   = (state_q == ACCESS);
  assign complete    = in_access && (bus.mem_ack || expired);
  assign rd          = bus.mem_ack ? bus.mem_rdata : '0;

  arb_timer #(
    .LIMIT   (WAIT_LIMIT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst),
    .clr     (!in_access),
    .en      (in_access),
    .expired (expired)
  );

  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (state_q == IDLE) begin
      unique case (1'b1)
        fetch_wins: grant_if = 1'b1;
        data_wins:  grant_d  = 1'b1;
        default:    ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_if || grant_d) state_d = ACCESS;
      ACCESS:  if (complete) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (grant_if) begin
      starve_q <= '0;
    end else if (grant_d && bus.if_req && !starve_full) begin
      starve_q <= starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q     <= OWN_IF;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (grant_if) begin
      owner_q     <= OWN_IF;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= bus.if_addr;
      mem_wdata_q <= '0;
    end else if (grant_d) begin
      owner_q     <= OWN_D;
      mem_we_q    <= bus.d_we;
      mem_addr_q  <= bus.d_addr;
      mem_wdata_q <= bus.d_wdata;
    end
  end

  // Completion results land in the DONE cycle; rdata holds afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
      if (complete) begin
        err_q <= !bus.mem_ack;
        if (owner_q == OWN_IF) begin
          if_done_q  <= 1'b1;
          if_rdata_q <= rd;
        end else begin
          d_done_q  <= 1'b1;
          d_rdata_q <= mem_we_q ? '0 : rd;
        end
      end
    end
  end

  assign bus.mem_req   = in_access;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.err       = err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter.
// Memory model acks after a programmable wait.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    bit          is_if;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  int mem_wait;
  bit mem_noack;
  bit late_ack;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .WAIT_LIMIT   (15),
    .STARVE_LIMIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic push(input bit is_if, input logic [31:0] rd,
                      input bit e);
    exp_t x;
    x.is_if = is_if;
    x.rdata = rd;
    x.err   = e;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: counts request cycles, acks at cycle mem_wait.
  int req_cyc;
  bit prev_req;
  always begin
    @(posedge clk);
    #2;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    if (bus.mem_req) begin
      if (!mem_noack && req_cyc == mem_wait) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_word(bus.mem_addr);
      end
      req_cyc++;
    end else begin
      if (prev_req && late_ack) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBAD0BAD0;
      end
      req_cyc = 0;
    end
    prev_req = bus.mem_req;
  end

  // Scoreboard monitor.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.if_done || bus.d_done) begin
      if (sb.size() == 0) begin
        check("unexp_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sb_both", bus.if_done & bus.d_done, 0);
        check("sb_port", bus.if_done, e.is_if);
        check("sb_rdata", e.is_if ? bus.if_rdata : bus.d_rdata,
              e.rdata);
        check("sb_err", bus.err, e.err);
      end
    end
  end

  task automatic wait_done(input int budget,
                           input logic [31:0] ea,
                           input logic [31:0] wd,
                           output int lat, output int req_n,
                           output int we_n, output int wd_n,
                           output int ad_n);
    lat = 0; req_n = 0; we_n = 0; wd_n = 0; ad_n = 0;
    forever begin
      tick();
      lat++;
      if (bus.mem_req) begin
        req_n++;
        if (bus.mem_we) we_n++;
        if (bus.mem_wdata == wd) wd_n++;
        if (bus.mem_addr == ea) ad_n++;
      end
      if (bus.if_done || bus.d_done) break;
      if (lat >= budget) begin
        check("wait_budget", lat, 0);
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat, rq, we, wd, ad, nd;
    logic [9:0] seq, seq_exp;
    n_checks = 0; n_fail = 0;
    mem_wait = 0; mem_noack = 0; late_ack = 0;
    rst = 1'b0;
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
    repeat (3) tick();
    check("rst_req", bus.mem_req, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_done", {bus.if_done, bus.d_done, bus.err}, 0);
    check("rst_rdata", {bus.if_rdata, bus.d_rdata}, 0);
    #2 rst = 1'b1;
    tick();

    // Fetch, zero wait: done two cycles after request.
    bus.if_addr = 32'h100; bus.if_req = 1;
    push(1, 32'hDEADBEEF, 0);
    wait_done(20, 32'h100, 0, lat, rq, we, wd, ad);
    bus.if_req = 0;
    check("if_lat", lat, 2);
    check("if_reqcyc", rq, 1);
    check("if_we", we, 0);
    check("if_addr", ad, 1);
    tick();

    // Store with two wait states.
    mem_wait = 2;
    bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678;
    bus.d_we = 1; bus.d_req = 1;
    push(0, 0, 0);
    wait_done(20, 32'h200, 32'h12345678, lat, rq, we, wd, ad);
    bus.d_req = 0; bus.d_we = 0;
    check("st_lat", lat, 4);
    check("st_reqcyc", rq, 3);
    check("st_we", we, 3);
    check("st_wdata", wd, 3);
    check("st_addr", ad, 3);
    tick();

    // Ack in the last allowed cycle beats the timeout.
    mem_wait = 14;
    bus.d_addr = 32'h240; bus.d_req = 1;
    push(0, mem_word(32'h240), 0);
    wait_done(40, 32'h240, 0, lat, rq, we, wd, ad);
    bus.d_req = 0;
    check("lim_reqcyc", rq, 15);
    check("lim_lat", lat, 16);
    tick();

    // No ack: timeout with err, late ack ignored.
    mem_noack = 1; late_ack = 1;
    bus.d_addr = 32'h300; bus.d_req = 1;
    push(0, 0, 1);
    wait_done(40, 32'h300, 0, lat, rq, we, wd, ad);
    bus.d_req = 0;
    check("to_reqcyc", rq, 15);
    check("to_lat", lat, 16);
    nd = 0;
    repeat (4) begin
      tick();
      if (bus.if_done || bus.d_done) nd++;
    end
    check("late_ack", nd, 0);
    mem_noack = 0; late_ack = 0;

    // Both requesting continuously: four data, then one fetch.
    mem_wait = 0;
    bus.if_addr = 32'h1000; bus.d_addr = 32'h2000;
    bus.if_req = 1; bus.d_req = 1;
    for (int i = 0; i < 10; i++) begin
      seq_exp[i] = (i % 5 == 4);
      push(seq_exp[i], mem_word(seq_exp[i] ? 32'h1000 : 32'h2000), 0);
    end
    for (int i = 0; i < 10; i++) begin
      wait_done(20, 0, 0, lat, rq, we, wd, ad);
      seq[i] = bus.if_done;
      if (i == 1) check("b2b_lat", lat, 3);
      if (i == 9) begin
        bus.if_req = 0; bus.d_req = 0;
      end
    end
    check("starve_seq", seq, seq_exp);
    tick();

    // Reset during the fourth data access (starve at limit).
    mem_wait = 3;
    bus.if_req = 1; bus.d_req = 1;
    for (int i = 0; i < 3; i++) push(0, mem_word(32'h2000), 0);
    for (int i = 0; i < 3; i++)
      wait_done(20, 0, 0, lat, rq, we, wd, ad);
    tick();
    tick();
    check("pre_rst_req", bus.mem_req, 1);
    check("pre_rst_addr", bus.mem_addr, 32'h2000);
    #3 rst = 1'b0;
    #1;
    check("rst_async", bus.mem_req, 0);
    check("rst_outs", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    nd = 0;
    repeat (3) begin
      tick();
      if (bus.if_done || bus.d_done || bus.mem_req) nd++;
    end
    check("rst_quiet", nd, 0);
    #2 rst = 1'b1;
    push(0, mem_word(32'h2000), 0);
    wait_done(20, 0, 0, lat, rq, we, wd, ad);
    check("post_rst_d", bus.d_done, 1);
    bus.if_req = 0; bus.d_req = 0;
    repeat (3) tick();
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
